// File: rtl/game_ram_arbiter_pkg.sv
// Shared definitions for the game-board RAM arbiter: board geometry
// defaults, cell codes stored in the RAM and the arbiter FSM states.
package game_ram_arbiter_pkg;

  localparam int BOARD_W_DEF = 124;
  localparam int BOARD_H_DEF = 92;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_SNAKE = 2'b01,
    CELL_HEAD  = 2'b10,
    CELL_FOOD  = 2'b11
  } cell_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_t;

endpackage

// File: rtl/game_ram_arbiter_addr_calc.sv
// Cell coordinate to linear RAM address (y*BOARD_W + x) plus a flag telling
// whether the coordinate lies on the board. One instance per requester.
module board_addr_calc
  import game_ram_arbiter_pkg::*;
#(
  parameter int BOARD_W    = BOARD_W_DEF,
  parameter int BOARD_H    = BOARD_H_DEF,
  parameter int ADDR_WIDTH = 14
) (
  input  logic [6:0]            x,
  input  logic [6:0]            y,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  in_range
);

  // Full-width multiply-add; 127*124+127 still fits in 14 bits, so even
  // out-of-range coordinates never wrap onto a valid cell.
  always_comb begin
    addr     = ADDR_WIDTH'(y) * ADDR_WIDTH'(BOARD_W) + ADDR_WIDTH'(x);
    in_range = (32'(x) < 32'(BOARD_W)) && (32'(y) < 32'(BOARD_H));
  end

endmodule

// File: rtl/game_ram_arbiter.sv
// Single-port game-board RAM owner: clears the board after reset or on
// request, then arbitrates each cycle between the VGA reader and the game
// engine, with a starvation guard that forces the game a slot.
module game_ram_arbiter
  import game_ram_arbiter_pkg::*;
#(
  parameter int BOARD_W      = BOARD_W_DEF,
  parameter int BOARD_H      = BOARD_H_DEF,
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  output logic                  clearing,
  input  logic                  vga_req,
  input  logic [6:0]            vga_x,
  input  logic [6:0]            vga_y,
  output logic                  vga_gnt,
  output logic [DATA_WIDTH-1:0] vga_rdata,
  output logic                  vga_rvalid,
  input  logic                  game_req,
  input  logic                  game_we,
  input  logic [6:0]            game_x,
  input  logic [6:0]            game_y,
  input  logic [DATA_WIDTH-1:0] game_wdata,
  output logic                  game_gnt,
  output logic [DATA_WIDTH-1:0] game_rdata,
  output logic                  game_rvalid,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic [ADDR_WIDTH-1:0] CLEAR_LAST = ADDR_WIDTH'(BOARD_W * BOARD_H - 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t            state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
  logic [SW-1:0]         starve_cnt, starve_nxt;
  logic                  starved;

  logic [ADDR_WIDTH-1:0] vga_addr, game_addr;
  logic                  vga_in_range, game_in_range;

  logic                  vga_pend, vga_pend_rng, game_pend, game_pend_rng;
  logic [DATA_WIDTH-1:0] vga_hold, game_hold;

  board_addr_calc #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H), .ADDR_WIDTH(ADDR_WIDTH)) u_vga_addr (
    .x        (vga_x),
    .y        (vga_y),
    .addr     (vga_addr),
    .in_range (vga_in_range)
  );

  board_addr_calc #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H), .ADDR_WIDTH(ADDR_WIDTH)) u_game_addr (
    .x        (game_x),
    .y        (game_y),
    .addr     (game_addr),
    .in_range (game_in_range)
  );

  // Next-state, arbitration and RAM port drive.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    starve_nxt  = starve_cnt;
    starved     = (starve_cnt == STARVE_MAX);
    vga_gnt     = 1'b0;
    game_gnt    = 1'b0;
    clearing    = 1'b0;
    ram_addr    = '0;
    ram_we      = 1'b0;
    ram_wdata   = '0;
    case (state)
      ST_CLEAR: begin
        clearing   = 1'b1;
        ram_we     = 1'b1;
        ram_addr   = clr_cnt;
        ram_wdata  = DATA_WIDTH'(CELL_EMPTY);
        starve_nxt = '0;
        if (clr_cnt == CLEAR_LAST) begin
          state_nxt   = ST_RUN;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (vga_req && !starved) begin
          vga_gnt  = 1'b1;
          ram_addr = vga_addr;
        end else if (game_req) begin
          game_gnt  = 1'b1;
          ram_addr  = game_addr;
          ram_we    = game_we && game_in_range;
          ram_wdata = game_wdata;
        end
        if (game_req && !game_gnt) begin
          starve_nxt = starved ? starve_cnt : starve_cnt + 1'b1;
        end else begin
          starve_nxt = '0;
        end
        // The grant issued alongside clear_req still completes; its read
        // return is carried by the pipeline registers below.
        if (clear_req) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  // FSM, clear counter and starvation counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_CLEAR;
      clr_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      clr_cnt    <= clr_cnt_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Read-return pipeline: remember which requester read and whether the
  // cell was on the board; hold the last returned data.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_pend      <= 1'b0;
      vga_pend_rng  <= 1'b0;
      game_pend     <= 1'b0;
      game_pend_rng <= 1'b0;
      vga_hold      <= '0;
      game_hold     <= '0;
    end else begin
      vga_pend      <= vga_gnt;
      vga_pend_rng  <= vga_in_range;
      game_pend     <= game_gnt && !game_we;
      game_pend_rng <= game_in_range;
      if (vga_pend)  vga_hold  <= vga_rdata;
      if (game_pend) game_hold <= game_rdata;
    end
  end

  // Read data: live RAM output in the return cycle, held value otherwise.
  always_comb begin
    vga_rvalid  = vga_pend;
    game_rvalid = game_pend;
    vga_rdata   = vga_pend  ? (vga_pend_rng  ? ram_q : '0) : vga_hold;
    game_rdata  = game_pend ? (game_pend_rng ? ram_q : '0) : game_hold;
  end

endmodule

// File: tb/tb_game_ram_arbiter.sv
// Randomised scoreboard bench for game_ram_arbiter with a behavioural RAM
// and a board/arbitration reference model.
module tb_game_ram_arbiter;

  localparam int W = 124;
  localparam int H = 92;
  localparam int CELLS = W * H;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset, clear_req, clearing;
  logic        vga_req, vga_gnt, vga_rvalid;
  logic [6:0]  vga_x, vga_y;
  logic [1:0]  vga_rdata;
  logic        game_req, game_we, game_gnt, game_rvalid;
  logic [6:0]  game_x, game_y;
  logic [1:0]  game_wdata, game_rdata;
  logic [13:0] ram_addr;
  logic        ram_we;
  logic [1:0]  ram_wdata, ram_q;

  game_ram_arbiter #(.BOARD_W(W), .BOARD_H(H), .ADDR_WIDTH(14), .DATA_WIDTH(2), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .clearing(clearing),
    .vga_req(vga_req), .vga_x(vga_x), .vga_y(vga_y), .vga_gnt(vga_gnt),
    .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
    .game_req(game_req), .game_we(game_we), .game_x(game_x), .game_y(game_y),
    .game_wdata(game_wdata), .game_gnt(game_gnt), .game_rdata(game_rdata),
    .game_rvalid(game_rvalid),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one registered read cycle.
  logic [1:0] mem [0:16383];
  initial foreach (mem[i]) mem[i] = 2'b00;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [1:0] d; int due; } exp_t;
  exp_t vga_q[$];
  exp_t game_q[$];

  int vectors = 0;
  int miscompares = 0;

  logic [1:0] ref_board [0:CELLS-1];
  bit  model_run;
  int  clr_expect;
  int  streak;
  bit  obs_clearing, obs_vga_gnt, obs_game_gnt, obs_we;
  int  obs_addr;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit on_board(input int x, input int y);
    return (x < W) && (y < H);
  endfunction

  task automatic model_reset();
    model_run  = 1'b0;
    clr_expect = 0;
    streak     = 0;
    foreach (ref_board[i]) ref_board[i] = 2'b00;
  endtask

  // One clock: drive at posedge+1, check at negedge, return at next posedge+1.
  task automatic cycle(input bit vr, input int vx, input int vy,
                       input bit gr, input bit gw, input int gx, input int gy,
                       input logic [1:0] gd, input bit cr);
    bit ev, eg;
    exp_t e;
    vga_req = vr; vga_x = 7'(vx); vga_y = 7'(vy);
    game_req = gr; game_we = gw; game_x = 7'(gx); game_y = 7'(gy); game_wdata = gd;
    clear_req = cr;
    @(negedge clk);
    obs_clearing = clearing; obs_vga_gnt = vga_gnt; obs_game_gnt = game_gnt;
    obs_we = ram_we; obs_addr = int'(ram_addr);
    if (model_run) begin
      ev = vr && (streak < LIMIT);
      eg = !ev && gr;
      check("vga_gnt", int'(vga_gnt), int'(ev));
      check("game_gnt", int'(game_gnt), int'(eg));
      check("clearing_run", int'(clearing), 0);
      if (ev) begin
        check("vga_addr", int'(ram_addr), vy * W + vx);
        check("vga_we", int'(ram_we), 0);
        e.d = on_board(vx, vy) ? ref_board[vy * W + vx] : 2'b00;
        e.due = cyc + 1;
        vga_q.push_back(e);
      end else if (eg) begin
        check("game_addr", int'(ram_addr), gy * W + gx);
        if (gw) begin
          check("game_we", int'(ram_we), int'(on_board(gx, gy)));
          if (on_board(gx, gy)) begin
            check("game_wdata", int'(ram_wdata), int'(gd));
            ref_board[gy * W + gx] = gd;
          end
        end else begin
          check("game_rd_we", int'(ram_we), 0);
          e.d = on_board(gx, gy) ? ref_board[gy * W + gx] : 2'b00;
          e.due = cyc + 1;
          game_q.push_back(e);
        end
      end else begin
        check("idle_we", int'(ram_we), 0);
        check("idle_addr", int'(ram_addr), 0);
      end
      streak = (gr && !eg) ? ((streak < LIMIT) ? streak + 1 : LIMIT) : 0;
      if (cr) begin
        model_run  = 1'b0;
        clr_expect = 0;
        streak     = 0;
      end
    end else begin
      check("clear_gnt", int'({vga_gnt, game_gnt}), 0);
      check("clear_we", int'(ram_we), 1);
      check("clear_addr", int'(ram_addr), clr_expect);
      check("clear_wdata", int'(ram_wdata), 0);
      check("clearing", int'(clearing), 1);
      clr_expect++;
      if (clr_expect == CELLS) begin
        model_run = 1'b1;
        streak    = 0;
        foreach (ref_board[i]) ref_board[i] = 2'b00;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic rnd_cycle();
    int vx, vy, gx, gy;
    if ($urandom_range(0, 7) == 0) begin vx = $urandom_range(0, 127); vy = $urandom_range(0, 127); end
    else begin vx = $urandom_range(0, 7); vy = $urandom_range(0, 3); end
    if ($urandom_range(0, 7) == 0) begin gx = $urandom_range(0, 127); gy = $urandom_range(0, 127); end
    else begin gx = $urandom_range(0, 7); gy = $urandom_range(0, 3); end
    cycle($urandom_range(0, 3) != 0, vx, vy, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          gx, gy, 2'($urandom_range(0, 3)), 1'b0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    vga_req = 1'b0; game_req = 1'b0; clear_req = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      check("rst_vga_rvalid", int'(vga_rvalid), 0);
      check("rst_game_rvalid", int'(game_rvalid), 0);
      check("rst_vga_rdata", int'(vga_rdata), 0);
      check("rst_game_rdata", int'(game_rdata), 0);
      check("rst_clearing", int'(clearing), 1);
    end
    model_reset();
    vga_q.delete();
    game_q.delete();
    reset = 1'b0;
  endtask

  // Runs random traffic until the DUT leaves CLEAR; returns clearing cycles seen.
  task automatic run_clear(output int n);
    n = 0;
    for (int i = 0; i < 20000; i++) begin
      rnd_cycle();
      if (obs_clearing) n++;
      else break;
    end
  endtask

  // Scoreboard monitor: pops expected read data whenever a return appears.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (vga_rvalid) begin
        if (vga_q.size() == 0) check("vga_rvalid_unexpected", 1, 0);
        else begin
          e = vga_q.pop_front();
          check("vga_rdata", int'(vga_rdata), int'(e.d));
          check("vga_latency", cyc, e.due);
        end
      end else if (vga_q.size() != 0 && vga_q[0].due <= cyc) begin
        e = vga_q.pop_front();
        check("vga_rvalid_missing", 0, 1);
      end
      if (game_rvalid) begin
        if (game_q.size() == 0) check("game_rvalid_unexpected", 1, 0);
        else begin
          e = game_q.pop_front();
          check("game_rdata", int'(game_rdata), int'(e.d));
          check("game_latency", cyc, e.due);
        end
      end else if (game_q.size() != 0 && game_q[0].due <= cyc) begin
        e = game_q.pop_front();
        check("game_rvalid_missing", 0, 1);
      end
    end
  end

  initial begin
    int n, first_game, vga_after;
    reset = 1'b1; clear_req = 1'b0;
    vga_req = 1'b0; vga_x = '0; vga_y = '0;
    game_req = 1'b0; game_we = 1'b0; game_x = '0; game_y = '0; game_wdata = '0;
    model_reset();

    do_reset(3);
    run_clear(n);
    check("clear_len_after_reset", n, CELLS);

    // Write then read-after-write on the same cell.
    cycle(0, 0, 0, 1, 1, 3, 2, 2'b10, 0);
    check("wr_addr_251", obs_addr, 251);
    check("wr_we", int'(obs_we), 1);
    cycle(0, 0, 0, 1, 0, 3, 2, 2'b00, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);

    // Continuous contention: game forced in on the 9th cycle.
    first_game = 0; vga_after = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle(1, i, 1, 1, 0, 3, 2, 2'b00, 0);
      if (obs_game_gnt && first_game == 0) first_game = i;
      if (i == 10) vga_after = int'(obs_vga_gnt);
    end
    check("starve_first_game_gnt", first_game, LIMIT + 1);
    check("starve_vga_after", vga_after, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);

    // Off-board accesses.
    cycle(0, 0, 0, 1, 1, 124, 0, 2'b11, 0);
    check("oor_gnt", int'(obs_game_gnt), 1);
    check("oor_we", int'(obs_we), 0);
    cycle(0, 0, 0, 1, 0, 10, 92, 2'b00, 0);
    cycle(1, 0, 92, 0, 0, 0, 0, 2'b00, 0);

    repeat (3000) rnd_cycle();

    // clear_req alongside a game read grant.
    cycle(0, 0, 0, 1, 1, 7, 7, 2'b11, 0);
    cycle(0, 0, 0, 1, 0, 7, 7, 2'b00, 1);
    check("clrreq_gnt", int'(obs_game_gnt), 1);
    run_clear(n);
    check("clear_len_on_request", n, CELLS);
    cycle(0, 0, 0, 1, 0, 7, 7, 2'b00, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);

    // Reset part-way through a clear restarts it from address 0.
    cycle(0, 0, 0, 0, 0, 0, 0, 2'b00, 1);
    for (int i = 0; i < 6000 && clr_expect < 5000; i++) rnd_cycle();
    check("clear_reached_5000", clr_expect, 5000);
    do_reset(1);
    run_clear(n);
    check("clear_len_after_mid_reset", n, CELLS);

    repeat (200) rnd_cycle();
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    check("vga_q_drained", vga_q.size(), 0);
    check("game_q_drained", game_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
